// File: rtl/mem_req_arbiter.sv
// Two-requester (fetch / data) arbiter onto one shared memory port, one transaction in flight.
// Build option MEM_ARB_RR_EN: round-robin on collision; otherwise the data requester always wins.
module mem_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_strb,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  // state    | meaning
  // S_IDLE   | no transaction; arbitrate, m_req held low
  // S_I_ADDR | fetch request presented, waiting for m_addr_ok
  // S_I_DATA | fetch accepted, waiting for m_data_ok
  // S_D_ADDR | data request presented, waiting for m_addr_ok
  // S_D_DATA | data accepted, waiting for m_data_ok
  typedef enum logic [2:0] {
    S_IDLE,
    S_I_ADDR,
    S_I_DATA,
    S_D_ADDR,
    S_D_DATA
  } state_t;

  state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   grant_d;

  always_comb begin
    grant_d = d_req;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) grant_d = !last_d_q;
`endif
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d  = grant_d ? S_D_ADDR : S_I_ADDR;
          last_d_d = grant_d;
        end
      end
      S_I_ADDR: begin
        if (m_addr_ok)   state_d = S_I_DATA;
        else if (!i_req) state_d = S_IDLE;
      end
      S_I_DATA: if (m_data_ok) state_d = S_IDLE;
      S_D_ADDR: begin
        if (m_addr_ok)   state_d = S_D_DATA;
        else if (!d_req) state_d = S_IDLE;
      end
      S_D_DATA: if (m_data_ok) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Handshakes pass through combinationally; gating with resetn drops the
  // shared port and any late response in the very cycle reset is asserted.
  always_comb begin
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_size    = 2'd0;
    m_addr    = '0;
    m_wdata   = '0;
    m_strb    = '0;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    if (resetn) begin
      case (state_q)
        S_I_ADDR: begin
          m_req     = i_req;
          m_size    = 2'd2;
          m_addr    = i_addr;
          i_addr_ok = m_addr_ok;
        end
        S_I_DATA: i_data_ok = m_data_ok;
        S_D_ADDR: begin
          m_req     = d_req;
          m_wr      = d_wr;
          m_size    = d_size;
          m_addr    = d_addr;
          m_wdata   = d_wdata;
          m_strb    = d_strb;
          d_addr_ok = m_addr_ok;
        end
        S_D_DATA: d_data_ok = m_data_ok;
        default: ;
      endcase
    end
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours MEM_ARB_RR_EN.
module tb_mem_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_req, i_addr_ok, i_data_ok;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_wr, d_addr_ok, d_data_ok;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [3:0]    d_strb;
  logic          m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_strb;

  logic auto_mem, man_addr_ok, man_data_ok, pend;

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata), .m_strb(m_strb),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: accepts any request at once, answers the following cycle.
  assign m_addr_ok = auto_mem ? m_req : man_addr_ok;
  assign m_data_ok = auto_mem ? pend  : man_data_ok;
  always @(posedge clk) begin
    if (!resetn || !auto_mem) pend <= 1'b0;
    else                      pend <= m_req && m_addr_ok;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), whether the
  // address has been accepted, and who was granted last.
  int owner = 0;
  bit in_data = 1'b0;
  bit last_was_d = 1'b0;
  logic e_mreq, e_iao, e_ido, e_dao, e_ddo, x_req, pick_d;

  always @(negedge clk) begin
    e_mreq = 1'b0; e_iao = 1'b0; e_ido = 1'b0; e_dao = 1'b0; e_ddo = 1'b0;
    if (resetn && owner != 0) begin
      if (!in_data) begin
        e_mreq = (owner == 1) ? i_req : d_req;
        if (owner == 1) e_iao = m_addr_ok; else e_dao = m_addr_ok;
      end else begin
        if (owner == 1) e_ido = m_data_ok; else e_ddo = m_data_ok;
      end
    end
    chk1("cmp_m_req", m_req, e_mreq);
    chk1("cmp_i_addr_ok", i_addr_ok, e_iao);
    chk1("cmp_i_data_ok", i_data_ok, e_ido);
    chk1("cmp_d_addr_ok", d_addr_ok, e_dao);
    chk1("cmp_d_data_ok", d_data_ok, e_ddo);
    chk32("cmp_i_rdata", i_rdata, m_rdata);
    chk32("cmp_d_rdata", d_rdata, m_rdata);
    if (resetn && owner == 1 && !in_data) begin
      chk32("cmp_i_m_addr", m_addr, i_addr);
      chk1("cmp_i_m_wr", m_wr, 1'b0);
      chk32("cmp_i_m_size", 32'(m_size), 32'd2);
      chk32("cmp_i_m_strb", 32'(m_strb), 32'd0);
      chk32("cmp_i_m_wdata", m_wdata, 32'd0);
    end
    if (resetn && owner == 2 && !in_data) begin
      chk32("cmp_d_m_addr", m_addr, d_addr);
      chk1("cmp_d_m_wr", m_wr, d_wr);
      chk32("cmp_d_m_size", 32'(m_size), 32'(d_size));
      chk32("cmp_d_m_strb", 32'(m_strb), 32'(d_strb));
      chk32("cmp_d_m_wdata", m_wdata, d_wdata);
    end
    // advance model to the state after the coming rising edge
    if (!resetn) begin
      owner = 0;
      last_was_d = 1'b0;
    end else if (owner == 0) begin
      if (i_req && d_req) pick_d = RR ? !last_was_d : 1'b1;
      else                pick_d = d_req;
      if (i_req || d_req) begin
        owner = pick_d ? 2 : 1;
        in_data = 1'b0;
        last_was_d = pick_d;
      end
    end else if (!in_data) begin
      x_req = (owner == 1) ? i_req : d_req;
      if (m_addr_ok)   in_data = 1'b1;
      else if (!x_req) owner = 0;
    end else if (m_data_ok) begin
      owner = 0;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic collide(input bit d_first, input string tag);
    logic fa, fd, sa, sd, da, ia;
    auto_mem = 1'b1;
    i_req = 1'b1; i_addr = 32'hBFC00010;
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h80001000;
    d_strb = 4'hF; d_wdata = 32'h12345678;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      fa = d_first ? d_addr_ok : i_addr_ok;
      fd = d_first ? d_data_ok : i_data_ok;
      sa = d_first ? i_addr_ok : d_addr_ok;
      sd = d_first ? i_data_ok : d_data_ok;
      chk1({tag, "_first_addr_ok"}, fa, c == 1);
      chk1({tag, "_first_data_ok"}, fd, c == 2);
      chk1({tag, "_second_addr_ok"}, sa, c == 4);
      chk1({tag, "_second_data_ok"}, sd, c == 5);
      if (c == 1) chk1({tag, "_m_wr"}, m_wr, d_first);
      da = d_addr_ok;
      ia = i_addr_ok;
      nxt();
      if (da) d_req = 1'b0;
      if (ia) i_req = 1'b0;
    end
    auto_mem = 1'b0;
    d_wr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; auto_mem = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0;
    d_addr = '0; d_wdata = '0; d_strb = '0; m_rdata = '0;

    // reset
    nxt(); nxt();
    @(negedge clk);
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_i_addr_ok", i_addr_ok, 1'b0);
    chk1("rst_d_data_ok", d_data_ok, 1'b0);
    nxt();
    resetn = 1'b1;
    nxt();

    // single fetch
    i_req = 1'b1; i_addr = 32'hBFC00000;
    @(negedge clk); chk1("fetch_c0_m_req", m_req, 1'b0);
    nxt();
    man_addr_ok = 1'b1;
    @(negedge clk);
    chk1("fetch_c1_i_addr_ok", i_addr_ok, 1'b1);
    chk1("fetch_c1_m_req", m_req, 1'b1);
    chk32("fetch_c1_m_addr", m_addr, 32'hBFC00000);
    chk1("fetch_c1_m_wr", m_wr, 1'b0);
    nxt();
    i_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1; m_rdata = 32'h3C1D8000;
    @(negedge clk);
    chk1("fetch_c2_i_data_ok", i_data_ok, 1'b1);
    chk32("fetch_c2_i_rdata", i_rdata, 32'h3C1D8000);
    chk1("fetch_c2_d_data_ok", d_data_ok, 1'b0);
    nxt();
    man_data_ok = 1'b0;
    nxt();

    // collision with last grant = fetch: data first in both builds
    collide(1'b1, "colA");

    // stalled memory on a data write while fetch waits
    i_req = 1'b1; i_addr = 32'h00400000;
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'd1; d_addr = 32'h80002000;
    d_wdata = 32'hCAFEF00D; d_strb = 4'h3;
    nxt();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("stall_m_req", m_req, 1'b1);
      chk32("stall_m_addr", m_addr, 32'h80002000);
      chk32("stall_m_wdata", m_wdata, 32'hCAFEF00D);
      chk1("stall_i_addr_ok", i_addr_ok, 1'b0);
      nxt();
    end
    man_addr_ok = 1'b1;
    @(negedge clk); chk1("stall_d_addr_ok", d_addr_ok, 1'b1);
    nxt();
    d_req = 1'b0; i_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1; m_rdata = 32'h0BAD0001;
    @(negedge clk); chk1("stall_d_data_ok", d_data_ok, 1'b1);
    nxt();
    man_data_ok = 1'b0; d_wr = 1'b0;
    nxt();

    // collision with last grant = data: round-robin serves fetch first
    collide(!RR, "colB");

    // abandoned data request
    d_req = 1'b1; d_addr = 32'h80003000;
    nxt();
    d_req = 1'b0;
    @(negedge clk);
    chk1("abandon_c1_m_req", m_req, 1'b0);
    chk1("abandon_c1_d_addr_ok", d_addr_ok, 1'b0);
    nxt();
    i_req = 1'b1; i_addr = 32'h00001000;
    @(negedge clk); chk1("abandon_c2_m_req", m_req, 1'b0);
    nxt();
    man_addr_ok = 1'b1;
    @(negedge clk);
    chk1("abandon_c3_m_req", m_req, 1'b1);
    chk1("abandon_c3_i_addr_ok", i_addr_ok, 1'b1);
    nxt();
    i_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1;
    @(negedge clk);
    chk1("abandon_c4_i_data_ok", i_data_ok, 1'b1);
    chk1("abandon_c4_d_data_ok", d_data_ok, 1'b0);
    nxt();
    man_data_ok = 1'b0;
    nxt();

    // spurious handshakes in IDLE and I_ADDR
    man_data_ok = 1'b1; man_addr_ok = 1'b1;
    @(negedge clk);
    chk1("spur_idle_i_data_ok", i_data_ok, 1'b0);
    chk1("spur_idle_d_data_ok", d_data_ok, 1'b0);
    chk1("spur_idle_i_addr_ok", i_addr_ok, 1'b0);
    nxt();
    man_addr_ok = 1'b0; i_req = 1'b1; i_addr = 32'h00002000;
    nxt();
    @(negedge clk);
    chk1("spur_iaddr_m_req", m_req, 1'b1);
    chk1("spur_iaddr_i_data_ok", i_data_ok, 1'b0);
    chk1("spur_iaddr_d_data_ok", d_data_ok, 1'b0);
    nxt();
    man_data_ok = 1'b0; man_addr_ok = 1'b1;
    @(negedge clk); chk1("spur_i_addr_ok", i_addr_ok, 1'b1);
    nxt();
    i_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1;
    @(negedge clk); chk1("spur_i_data_ok", i_data_ok, 1'b1);
    nxt();
    man_data_ok = 1'b0;
    nxt();

    // reset during D_DATA
    d_req = 1'b1; d_addr = 32'h80004000;
    nxt();
    man_addr_ok = 1'b1;
    @(negedge clk); chk1("rstd_d_addr_ok", d_addr_ok, 1'b1);
    nxt();
    d_req = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b1; resetn = 1'b0;
    @(negedge clk);
    chk1("rstd_d_data_ok_in_reset", d_data_ok, 1'b0);
    chk1("rstd_m_req_in_reset", m_req, 1'b0);
    nxt();
    resetn = 1'b1;
    @(negedge clk);
    chk1("rstd_late_d_data_ok", d_data_ok, 1'b0);
    chk1("rstd_late_i_data_ok", i_data_ok, 1'b0);
    nxt();
    man_data_ok = 1'b0;
    nxt();

    // after reset the grant history is cleared: data wins in both builds
    collide(1'b1, "colR");
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
